// File: rtl/eth_header_parser_if.sv
// rtl/eth_header_parser_if.sv - byte-wide stream bundle shared by the parser's input and output sides
interface eth_header_parser_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  // Producer drives data/valid/last and observes ready.
  modport master (output tdata, output tvalid, output tlast, input tready);
  // Consumer observes data/valid/last and drives ready.
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_header_parser.sv
// rtl/eth_header_parser.sv - Ethernet II header extractor with payload forwarding and EtherType filter
module eth_header_parser #(
  parameter bit          FILTER_EN        = 1'b0,
  parameter logic [15:0] ETHERTYPE_ACCEPT = 16'h0800
) (
  input  logic                        clk,
  input  logic                        rst_n,
  eth_header_parser_if.slave          s_axis,
  eth_header_parser_if.master         m_axis,
  output logic [47:0]                 dst_mac,
  output logic [47:0]                 src_mac,
  output logic [15:0]                 ethertype,
  output logic                        hdr_valid,
  output logic                        runt_err,
  output logic                        drop_pulse
);

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [103:0]  hdr_sh_q;       // header bytes 0..12, oldest in the top byte
  logic [111:0]  hdr_full_d;     // complete header when byte 13 is on the bus
  logic [47:0]   dst_mac_q;
  logic [47:0]   src_mac_q;
  logic [15:0]   ethertype_q;
  logic          hdr_valid_q;
  logic          runt_err_q;
  logic          drop_pulse_q;
  logic [7:0]    m_tdata_q;
  logic          m_tvalid_q;
  logic          m_tlast_q;
  logic          s_ready_d;
  logic          s_fire_d;

  assign hdr_full_d = {hdr_sh_q, s_axis.tdata};
  assign s_fire_d   = s_axis.tvalid && s_ready_d;

  // Ready depends only on state and the output register, never on s_axis.tvalid.
  always_comb begin
    s_ready_d = 1'b1;
    if (state_q == ST_PAYLOAD) begin
      s_ready_d = !m_tvalid_q || m_axis.tready;
    end
  end

  // Parser FSM, header capture, one-entry output register and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HEADER;
      cnt_q        <= 4'd0;
      hdr_sh_q     <= '0;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      ethertype_q  <= '0;
      hdr_valid_q  <= 1'b0;
      runt_err_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
    end else begin
      hdr_valid_q  <= 1'b0;
      runt_err_q   <= 1'b0;
      drop_pulse_q <= 1'b0;

      // A pending beat retires on handshake; a same-cycle load below overrides this.
      if (m_tvalid_q && m_axis.tready) begin
        m_tvalid_q <= 1'b0;
      end

      if (s_fire_d) begin
        case (state_q)
          ST_HEADER: begin
            if (s_axis.tlast) begin
              // Short frame: header registers keep the last complete header.
              runt_err_q <= 1'b1;
              cnt_q      <= 4'd0;
            end else if (cnt_q == 4'd13) begin
              cnt_q       <= 4'd0;
              dst_mac_q   <= hdr_full_d[111:64];
              src_mac_q   <= hdr_full_d[63:16];
              ethertype_q <= hdr_full_d[15:0];
              if (FILTER_EN && (hdr_full_d[15:0] != ETHERTYPE_ACCEPT)) begin
                state_q      <= ST_DROP;
                drop_pulse_q <= 1'b1;
              end else begin
                state_q     <= ST_PAYLOAD;
                hdr_valid_q <= 1'b1;
              end
            end else begin
              hdr_sh_q <= {hdr_sh_q[95:0], s_axis.tdata};
              cnt_q    <= cnt_q + 4'd1;
            end
          end
          ST_PAYLOAD: begin
            m_tdata_q  <= s_axis.tdata;
            m_tlast_q  <= s_axis.tlast;
            m_tvalid_q <= 1'b1;
            if (s_axis.tlast) begin
              state_q <= ST_HEADER;
              cnt_q   <= 4'd0;
            end
          end
          ST_DROP: begin
            if (s_axis.tlast) begin
              state_q <= ST_HEADER;
              cnt_q   <= 4'd0;
            end
          end
          default: begin
            state_q <= ST_HEADER;
            cnt_q   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign s_axis.tready = s_ready_d;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign dst_mac       = dst_mac_q;
  assign src_mac       = src_mac_q;
  assign ethertype     = ethertype_q;
  assign hdr_valid     = hdr_valid_q;
  assign runt_err      = runt_err_q;
  assign drop_pulse    = drop_pulse_q;

endmodule

// File: doc/eth_header_parser.md
Name: eth_header_parser

Overview:
- Byte-wide Ethernet II header extractor.
- Consumes a frame on an 8-bit AXI4-Stream slave and captures destination MAC, source MAC and EtherType into registers.
- Forwards only the payload bytes on an 8-bit AXI4-Stream master to the next byte-size parsing stage (IPv4/ARP).
- Optionally drops frames whose EtherType does not match a configured value.

Parameters:
- FILTER_EN, 0: 1 drops frames whose EtherType != ETHERTYPE_ACCEPT.
- ETHERTYPE_ACCEPT, 16'h0800: accepted EtherType when FILTER_EN=1.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  8  frame byte, first byte = dst MAC[47:40].
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  parser accepts byte.
- s_axis_tlast  in  1  last byte of frame.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  payload byte valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tlast  out  1  last payload byte.
- dst_mac  out  48  captured destination MAC, byte 0 in [47:40].
- src_mac  out  48  captured source MAC, byte 6 in [47:40].
- ethertype  out  16  captured EtherType, byte 12 in [15:8].
- hdr_valid  out  1  one-cycle pulse: header of an accepted frame complete.
- runt_err  out  1  one-cycle pulse: tlast seen at or before header byte 13.
- drop_pulse  out  1  one-cycle pulse: frame rejected by filter.

Behaviour:
- Reset (rst_n low, asynchronous): state=HEADER, byte count=0; dst_mac/src_mac/ethertype=0; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; hdr_valid/runt_err/drop_pulse=0.
- Reset asserted mid-frame discards the frame. After release, the next accepted byte is treated as header byte 0.
- A byte is accepted when s_axis_tvalid && s_axis_tready. Nothing advances otherwise.
- States:
  - HEADER: s_axis_tready=1. A 4-bit count (0..13) indexes the byte into a header shift/load register. Accepted byte with count==13 and tlast=0 leads to a check: if FILTER_EN && EtherType != ETHERTYPE_ACCEPT, go to DROP and pulse drop_pulse next cycle; else go to PAYLOAD and pulse hdr_valid next cycle. Accepted byte with tlast=1 at any count 0..13 pulses runt_err, resets count to 0 and stays in HEADER; hdr_valid is not pulsed.
  - PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready (one-entry output register, no combinational path from s_axis_tvalid to s_axis_tready). Accepted byte loads m_axis_tdata/tlast and sets m_axis_tvalid on the next edge. Accepted byte with tlast=1 goes to HEADER with count=0.
  - DROP: s_axis_tready=1, bytes discarded. Accepted tlast goes to HEADER.
- Output register: m_axis_tvalid clears on m_axis_tready && m_axis_tvalid unless a new byte loads the same cycle. Simultaneous pop and load keeps tvalid=1 with new data. Data and tlast hold stable while tvalid && !tready.
- Latency: payload byte appears on m_axis one cycle after acceptance. Full throughput (1 byte/cycle) when m_axis_tready=1.
- Header output registers (dst_mac, src_mac, ethertype):
  - Update only when a full 14-byte header completes.
  - Runt bytes never corrupt them; they hold the last complete header.
  - For dropped frames they update and drop_pulse fires instead of hdr_valid.
  - They are valid from the hdr_valid cycle until the next header completes.
- Back-to-back frames: the first byte after a payload tlast is header byte 0, with no idle cycle required. In PAYLOAD the last output byte may still be pending while HEADER accepts the next frame.
- A header-only frame (tlast on byte 13) is treated as runt: runt_err pulses, no hdr_valid, no payload.
- tlast on the first payload byte (frame of 15 bytes) is legal: one payload byte is emitted with m_axis_tlast=1.

Test Plan:
- 64-byte frame, dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, type 0x0800, payload 0x00..0x31, m_tready=1 -> hdr_valid one pulse; dst_mac=48'hFFFFFFFFFFFF, src_mac=48'h001122334455, ethertype=16'h0800; 50 payload bytes 0x00..0x31 each 1 cycle after input; tlast on 0x31.
- Same frame with m_axis_tready toggled randomly 50% -> identical payload sequence, no loss or duplication, tdata stable while stalled, s_axis_tready low only when the output register is full and stalled.
- 10-byte frame with tlast on byte 9, then a valid frame -> runt_err one pulse, no hdr_valid or m_axis output for the runt; second frame parsed correctly with header fields from the second frame.
- FILTER_EN=1, frame with type 0x0806 followed by a type 0x0800 frame -> first: drop_pulse, ethertype=16'h0806, zero m_axis beats; second: hdr_valid, payload forwarded.
- Two back-to-back frames with no idle gap and s_axis_tvalid held high -> two hdr_valid pulses, two m_axis_tlast beats, second header fields correct.
- rst_n pulsed low mid-payload (byte 20 of 64), then a new frame -> all outputs 0 immediately; new frame parsed from byte 0, no residual payload beat.
